// File: rtl/lstm_cell_state.sv
// LSTM cell-state update c = f*c_prev + i*g on one shared multiplier.
// Define LSTM_CELL_SAT_EN to saturate the result instead of wrapping it.
module lstm_cell_state #(
    parameter int xDW = 24,
    parameter int xFL = 14,
    parameter int AW  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  IN_valid,
    input  logic signed [xDW-1:0] f_IN,
    input  logic signed [xDW-1:0] i_IN,
    input  logic signed [xDW-1:0] g_IN,
    input  logic        [AW-1:0]  idx_IN,
    input  logic                  clr,
    input  logic                  ds_done,
    output logic                  IN_ready,
    output logic signed [xDW-1:0] c_OUT,
    output logic        [AW-1:0]  idx_OUT,
    output logic                  c_OUT_valid
);

    localparam int PW    = 2 * xDW;
    localparam int SW    = PW + 1;
    localparam int DEPTH = 1 << AW;

    localparam logic signed [SW-1:0] C_MAX = SW'({1'b0, {(xDW-1){1'b1}}});
    localparam logic signed [SW-1:0] C_MIN = ~C_MAX;

    typedef enum logic [2:0] {
        IDLE,
        MUL_F,
        MUL_I,
        ADD,
        ISSUE,
        WAIT_DS
    } state_t;

    state_t state, state_nx;

    logic signed [xDW-1:0] f_q, i_q, g_q, c_prev_q;
    logic        [AW-1:0]  idx_q;
    logic signed [PW-1:0]  term_f, term_i;
    logic signed [xDW-1:0] store [DEPTH];

    logic signed [xDW-1:0] mul_a, mul_b;
    logic signed [PW-1:0]  prod, prod_sh;
    logic signed [SW-1:0]  sum_w;
    logic signed [xDW-1:0] c_new;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state and handshake outputs
    always_comb begin
        state_nx    = state;
        IN_ready    = 1'b0;
        c_OUT_valid = 1'b0;
        case (state)
            IDLE: begin
                IN_ready = 1'b1;
                if (!clr && IN_valid) state_nx = MUL_F;
            end
            MUL_F:   state_nx = MUL_I;
            MUL_I:   state_nx = ADD;
            ADD:     state_nx = ISSUE;
            ISSUE: begin
                c_OUT_valid = 1'b1;
                state_nx    = WAIT_DS;
            end
            WAIT_DS: if (ds_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // shared multiplier: f*c_prev first, then i*g; the sum is kept wide
    // enough that it can never overflow before saturation/wrap
    always_comb begin
        mul_a   = (state == MUL_I) ? i_q : f_q;
        mul_b   = (state == MUL_I) ? g_q : c_prev_q;
        prod    = mul_a * mul_b;
        prod_sh = prod >>> xFL;
        sum_w   = {term_f[PW-1], term_f} + {term_i[PW-1], term_i};
`ifdef LSTM_CELL_SAT_EN
        if (sum_w > C_MAX)      c_new = xDW'(C_MAX);
        else if (sum_w < C_MIN) c_new = xDW'(C_MIN);
        else                    c_new = xDW'(sum_w);
`else
        c_new = xDW'(sum_w);
`endif
    end

    // operand capture, product terms, result register and state store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q      <= '0;
            i_q      <= '0;
            g_q      <= '0;
            c_prev_q <= '0;
            idx_q    <= '0;
            term_f   <= '0;
            term_i   <= '0;
            c_OUT    <= '0;
            idx_OUT  <= '0;
            for (int k = 0; k < DEPTH; k++) store[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        for (int k = 0; k < DEPTH; k++) store[k] <= '0;
                    end else if (IN_valid) begin
                        f_q      <= f_IN;
                        i_q      <= i_IN;
                        g_q      <= g_IN;
                        idx_q    <= idx_IN;
                        c_prev_q <= store[idx_IN];
                    end
                end
                MUL_F: term_f <= prod_sh;
                MUL_I: term_i <= prod_sh;
                ADD: begin
                    c_OUT        <= c_new;
                    idx_OUT      <= idx_q;
                    store[idx_q] <= c_new;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_cell_state.sv
// Scoreboard bench for lstm_cell_state: driver queues expected results,
// monitor pops and compares on every c_OUT_valid pulse.
module tb_lstm_cell_state;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               IN_valid = 1'b0;
    logic signed [23:0] f_IN = '0, i_IN = '0, g_IN = '0;
    logic        [3:0]  idx_IN = '0;
    logic               clr = 1'b0;
    logic               ds_done = 1'b0;
    logic               IN_ready;
    logic signed [23:0] c_OUT;
    logic        [3:0]  idx_OUT;
    logic               c_OUT_valid;

    typedef struct {
        int c;
        int idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

`ifdef LSTM_CELL_SAT_EN
    localparam int OVF_EXP = 8388607;
`else
    localparam int OVF_EXP = -1024;
`endif

    lstm_cell_state dut (
        .clk(clk),
        .rst(rst),
        .IN_valid(IN_valid),
        .f_IN(f_IN),
        .i_IN(i_IN),
        .g_IN(g_IN),
        .idx_IN(idx_IN),
        .clr(clr),
        .ds_done(ds_done),
        .IN_ready(IN_ready),
        .c_OUT(c_OUT),
        .idx_OUT(idx_OUT),
        .c_OUT_valid(c_OUT_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // monitor: every output pulse must match the head of the queue
    always @(negedge clk) begin
        if (c_OUT_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: got c=%0d idx=%0d, expected none",
                         c_OUT, idx_OUT);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("c_OUT", int'(c_OUT), e.c);
                chk("idx_OUT", int'(idx_OUT), e.idx);
            end
        end
    end

    // one request; optionally pokes IN_valid+clr while in WAIT_DS
    task automatic req(input int f, input int i, input int g,
                       input int idx, input int exp_c, input bit poke);
        exp_t e;
        @(negedge clk);
        f_IN     = 24'(f);
        i_IN     = 24'(i);
        g_IN     = 24'(g);
        idx_IN   = 4'(idx);
        IN_valid = 1'b1;
        chk("in_ready_idle", int'(IN_ready), 1);
        e.c   = exp_c;
        e.idx = idx;
        exp_q.push_back(e);
        @(posedge clk);
        #1 IN_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("latency_valid_n4", int'(c_OUT_valid), 1);
        @(negedge clk);
        chk("valid_one_cycle", int'(c_OUT_valid), 0);
        if (poke) begin
            f_IN     = 24'sd16384;
            i_IN     = 24'sd16384;
            g_IN     = 24'sd16384;
            idx_IN   = 4'(idx);
            IN_valid = 1'b1;
            clr      = 1'b1;
            chk("in_ready_wait", int'(IN_ready), 0);
            @(negedge clk);
            IN_valid = 1'b0;
            clr      = 1'b0;
        end
        ds_done = 1'b1;
        @(negedge clk);
        ds_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_c_OUT", int'(c_OUT), 0);
        chk("rst_idx_OUT", int'(idx_OUT), 0);
        chk("rst_valid", int'(c_OUT_valid), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(IN_ready), 1);

        req(0, 16384, 16384, 3, 16384, 0);
        req(8192, 16384, 8192, 3, 16384, 0);
        req(8192, 0, 0, 3, 8192, 0);
        req(0, 1, -1, 5, -1, 1);
        req(0, 8388607, 8388607, 7, OVF_EXP, 0);
        req(-16384, 0, 0, 5, 1, 0);
        req(0, -8192, 12288, 9, -6144, 0);
        req(-8192, 3, 5, 9, 3072, 0);
        req(100, 3, -5, 10, -1, 0);
        req(0, 16384, 16384, 6, 16384, 1);
        req(16384, 0, 0, 6, 16384, 0);

        // reset while the request sits in MUL_I
        @(negedge clk);
        f_IN     = 24'sd16384;
        i_IN     = '0;
        g_IN     = '0;
        idx_IN   = 4'd3;
        IN_valid = 1'b1;
        @(posedge clk);
        #1 IN_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_c_OUT", int'(c_OUT), 0);
        chk("midrst_idx_OUT", int'(idx_OUT), 0);
        chk("midrst_valid", int'(c_OUT_valid), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_in_ready", int'(IN_ready), 1);
        req(16384, 0, 0, 3, 0, 0);
        req(16384, 0, 0, 9, 0, 0);

        // clr and IN_valid together in IDLE
        req(0, 16384, 16384, 4, 16384, 0);
        @(negedge clk);
        f_IN     = '0;
        i_IN     = 24'sd16384;
        g_IN     = 24'sd16384;
        idx_IN   = 4'd4;
        IN_valid = 1'b1;
        clr      = 1'b1;
        @(posedge clk);
        #1;
        IN_valid = 1'b0;
        clr      = 1'b0;
        @(negedge clk);
        chk("clr_stays_idle", int'(IN_ready), 1);
        repeat (6) @(negedge clk);
        req(16384, 0, 0, 4, 0, 0);

        repeat (10) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
